guard_reset_seq: RTL

GUARD_RESET_SEQ -- requirements
Module: guard_reset_seq

---
 rtl/guard_reset_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/guard_reset_seq.sv
// Reset sequencer for a guarded slave: isolate, drain in-flight traffic,
// pulse the slave reset, clear the guards, then blank one cycle before re-arming.
module guard_reset_seq #(
  parameter int unsigned DrainCycles = 64,
  parameter int unsigned RstCycles   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_reset_req_i,
  input  logic       rd_reset_req_i,
  input  logic       outstanding_i,
  input  logic       irq_ack_i,
  output logic       isolate_o,
  output logic       slv_rst_o,
  output logic       reset_clear_o,
  output logic       busy_o,
  output logic       irq_o,
  output logic [2:0] cause_o
);

  localparam int unsigned MaxCycles = (DrainCycles > RstCycles) ? DrainCycles : RstCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] DrainLast = CntW'(DrainCycles - 1);
  localparam logic [CntW-1:0] RstLast   = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRAIN   = 3'd1;
  localparam logic [2:0] SLV_RST = 3'd2;
  localparam logic [2:0] CLEAR   = 3'd3;
  localparam logic [2:0] BLANK   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      cause_q, cause_d;
  logic            irq_q, irq_d;
  logic            isolate_q, isolate_d;
  logic            busy_q, busy_d;
  logic            slv_rst_q, slv_rst_d;
  logic            clear_q, clear_d;
  logic [2:0]      req_bits;

  assign req_bits = {1'b0, rd_reset_req_i, wr_reset_req_i};

  // Next state, shared dwell counter and sticky cause/irq bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    cause_d = cause_q;
    irq_d   = irq_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_reset_req_i || rd_reset_req_i) begin
          // A fresh request beats a coincident acknowledge.
          state_d = DRAIN;
          irq_d   = 1'b1;
          cause_d = (irq_ack_i ? 3'b000 : cause_q) | req_bits;
        end else if (irq_ack_i) begin
          irq_d   = 1'b0;
          cause_d = 3'b000;
        end
      end
      DRAIN: begin
        cause_d = cause_q | req_bits;
        if (!outstanding_i) begin
          state_d = SLV_RST;
          cnt_d   = '0;
        end else if (cnt_q >= DrainLast) begin
          state_d    = SLV_RST;
          cnt_d      = '0;
          cause_d[2] = 1'b1;
        end
      end
      SLV_RST: begin
        cause_d = cause_q | req_bits;
        if (cnt_q >= RstLast) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cause_d = cause_q | req_bits;
        state_d = BLANK;
        cnt_d   = '0;
      end
      BLANK: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    isolate_d = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
    slv_rst_d = (state_d == SLV_RST);
    clear_d   = (state_d == CLEAR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cause_q   <= 3'b000;
      irq_q     <= 1'b0;
      isolate_q <= 1'b0;
      busy_q    <= 1'b0;
      slv_rst_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      irq_q     <= irq_d;
      isolate_q <= isolate_d;
      busy_q    <= busy_d;
      slv_rst_q <= slv_rst_d;
      clear_q   <= clear_d;
    end
  end

  assign isolate_o     = isolate_q;
  assign slv_rst_o     = slv_rst_q;
  assign reset_clear_o = clear_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;
  assign cause_o       = cause_q;

endmodule
